encode_unit: RTL and testbench

ENCODE_UNIT -- requirements
Module: encode_unit

---
 rtl/encode_unit_if.sv | 31 +++
 rtl/encode_unit.sv | 195 +++++++++++++++++++
 tb/tb_encode_unit.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/encode_unit_if.sv
// Instruction-field input, encoded-word output stream and error report of encode_unit.
interface encode_unit_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_group;
   logic [3:0]  in_operator;
   logic [3:0]  in_rg1;
   logic [3:0]  in_rg2;
   logic [7:0]  in_val;
   logic [15:0] in_pc;
   logic [15:0] in_target;
   logic [15:0] in_ext;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_word;
   logic        out_last;
   logic        err_valid;
   logic [2:0]  err_code;

   modport master (
      output in_valid, in_group, in_operator, in_rg1, in_rg2, in_val,
             in_pc, in_target, in_ext, out_ready,
      input  in_ready, out_valid, out_word, out_last, err_valid, err_code
   );

   modport slave (
      input  in_valid, in_group, in_operator, in_rg1, in_rg2, in_val,
             in_pc, in_target, in_ext, out_ready,
      output in_ready, out_valid, out_word, out_last, err_valid, err_code
   );
endinterface

// File: rtl/encode_unit.sv
// Instruction encoder: validates decoded fields and emits one or two 16-bit words,
// or a one-cycle error report for rejected instructions.
module encode_unit (
   input  logic         clk,
   input  logic         rst_n,
   encode_unit_if.slave bus
);
   localparam int unsigned W_WORD = 16;
   localparam int unsigned W_DIFF = 17;

   localparam logic [3:0] GROUP_MATH_CONSTANT = 4'd0;
   localparam logic [3:0] GROUP_BRANCH_JUMPS  = 4'd1;
   localparam logic [3:0] GROUP_MATH_REG      = 4'd2;
   localparam logic [3:0] GROUP_MATH_EREG     = 4'd3;
   localparam logic [3:0] GROUP_SINGLE_REG    = 4'd4;
   localparam logic [3:0] GROUP_STACK         = 4'd5;
   localparam logic [3:0] GROUP_REG_MEMORY    = 4'd6;
   localparam logic [3:0] GROUP_EXTENDED      = 4'd7;
   localparam logic [3:0] GROUP_OTHERS        = 4'd8;
   localparam logic [3:0] GROUP_RETURN        = 4'd9;

   localparam logic [3:0] OP_PUSH = 4'd0;
   localparam logic [3:0] OP_POP  = 4'd1;
   localparam logic [3:0] OP_RET  = 4'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WORD = 2'd1,
      ST_EXT  = 2'd2
   } state_e;

   state_e              r_state, w_state_nxt;
   logic                r_out_valid, w_out_valid_nxt;
   logic [W_WORD-1:0]   r_out_word, w_out_word_nxt;
   logic                r_out_last, w_out_last_nxt;
   logic [W_WORD-1:0]   r_ext_word, w_ext_word_nxt;
   logic                r_err_valid, w_err_valid_nxt;
   logic [2:0]          r_err_code, w_err_code_nxt;

   logic [W_DIFF-1:0]   w_diff;
   logic                w_diff_bad;
   logic                w_unknown;
   logic                w_op_bad;
   logic                w_reg_bad;
   logic [2:0]          w_err;
   logic [W_WORD-1:0]   w_word;
   logic                w_hs;
   logic                w_accept;
   logic                w_in_ready;

   // Branch offset in 17-bit two's complement; legal only if it fits in 9 signed bits.
   assign w_diff     = W_DIFF'(bus.in_target) - W_DIFF'(bus.in_pc) + W_DIFF'(2);
   assign w_diff_bad = (w_diff[16:8] != {9{w_diff[8]}});

   // Field encoding and legality checks for the presented instruction.
   always_comb begin
      w_word    = '0;
      w_unknown = 1'b0;
      w_op_bad  = 1'b0;
      w_reg_bad = 1'b0;
      case (bus.in_group)
         GROUP_MATH_CONSTANT: begin
            w_word   = {bus.in_val, bus.in_rg1, bus.in_operator};
            w_op_bad = (bus.in_operator[1:0] == 2'b11);
         end
         GROUP_BRANCH_JUMPS:
            w_word = {w_diff[8:0], bus.in_operator, 3'b011};
         GROUP_MATH_REG:
            w_word = {bus.in_rg2, bus.in_rg1, bus.in_operator, 4'b0111};
         GROUP_MATH_EREG: begin
            w_word    = {3'b000, bus.in_rg2[1:0], bus.in_rg1[1:0], bus.in_operator, 5'b01111};
            w_reg_bad = (bus.in_rg1[3:2] != 2'b00) || (bus.in_rg2[3:2] != 2'b00);
         end
         GROUP_SINGLE_REG: begin
            w_word   = {2'b00, bus.in_rg1, bus.in_operator, 6'b011111};
            w_op_bad = (bus.in_operator == OP_PUSH) || (bus.in_operator == OP_POP);
         end
         GROUP_STACK: begin
            w_word   = {2'b00, bus.in_rg1, bus.in_operator, 6'b011111};
            w_op_bad = (bus.in_operator != OP_PUSH) && (bus.in_operator != OP_POP);
         end
         GROUP_REG_MEMORY: begin
            w_word    = {bus.in_rg2[1:0], bus.in_rg1, bus.in_operator[2:0], 7'b0111111};
            w_op_bad  = bus.in_operator[3];
            w_reg_bad = (bus.in_rg2[3:2] != 2'b00);
         end
         GROUP_EXTENDED:
            w_word = {4'b0000, bus.in_operator, 8'h7F};
         GROUP_OTHERS: begin
            w_word   = {4'b0000, bus.in_operator, 8'hFF};
            w_op_bad = (bus.in_operator != OP_RET);
         end
         GROUP_RETURN: begin
            w_word   = {4'b0000, bus.in_operator, 8'hFF};
            w_op_bad = (bus.in_operator == OP_RET);
         end
         default:
            w_unknown = 1'b1;
      endcase
   end

   always_comb begin
      if (w_unknown)
         w_err = 3'd1;
      else if (w_op_bad)
         w_err = 3'd2;
      else if (w_reg_bad)
         w_err = 3'd3;
      else if ((bus.in_group == GROUP_BRANCH_JUMPS) && w_diff_bad)
         w_err = 3'd4;
      else
         w_err = 3'd0;
   end

   // A new instruction may enter while the final word of the previous one leaves.
   assign w_hs       = r_out_valid && bus.out_ready;
   assign w_in_ready = rst_n && ((r_state == ST_IDLE) || (w_hs && r_out_last));
   assign w_accept   = bus.in_valid && w_in_ready;

   always_comb begin
      w_state_nxt     = r_state;
      w_out_valid_nxt = r_out_valid;
      w_out_word_nxt  = r_out_word;
      w_out_last_nxt  = r_out_last;
      w_ext_word_nxt  = r_ext_word;
      w_err_valid_nxt = 1'b0;
      w_err_code_nxt  = r_err_code;
      case (r_state)
         ST_IDLE: ;
         ST_WORD: begin
            if (w_hs) begin
               if (!r_out_last) begin
                  w_state_nxt    = ST_EXT;
                  w_out_word_nxt = r_ext_word;
                  w_out_last_nxt = 1'b1;
               end else begin
                  w_state_nxt     = ST_IDLE;
                  w_out_valid_nxt = 1'b0;
               end
            end
         end
         ST_EXT: begin
            if (w_hs) begin
               w_state_nxt     = ST_IDLE;
               w_out_valid_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_out_valid_nxt = 1'b0;
         end
      endcase
      if (w_accept) begin
         if (w_err != 3'd0) begin
            w_state_nxt     = ST_IDLE;
            w_out_valid_nxt = 1'b0;
            w_err_valid_nxt = 1'b1;
            w_err_code_nxt  = w_err;
         end else begin
            w_state_nxt     = ST_WORD;
            w_out_valid_nxt = 1'b1;
            w_out_word_nxt  = w_word;
            w_out_last_nxt  = (bus.in_group != GROUP_EXTENDED);
            w_ext_word_nxt  = bus.in_ext;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_out_word  <= '0;
         r_out_last  <= 1'b0;
         r_ext_word  <= '0;
         r_err_valid <= 1'b0;
         r_err_code  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_word  <= w_out_word_nxt;
         r_out_last  <= w_out_last_nxt;
         r_ext_word  <= w_ext_word_nxt;
         r_err_valid <= w_err_valid_nxt;
         r_err_code  <= w_err_code_nxt;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_word  = r_out_word;
   assign bus.out_last  = r_out_last;
   assign bus.err_valid = r_err_valid;
   assign bus.err_code  = r_err_code;
endmodule

// File: tb/tb_encode_unit.sv
// Self-checking bench for encode_unit: vector table through a word/error scoreboard,
// plus backpressure, reset-in-flight and back-to-back throughput sequences.
module tb_encode_unit;
   localparam logic [3:0] G_MC  = 4'd0;
   localparam logic [3:0] G_BR  = 4'd1;
   localparam logic [3:0] G_MR  = 4'd2;
   localparam logic [3:0] G_ER  = 4'd3;
   localparam logic [3:0] G_SR  = 4'd4;
   localparam logic [3:0] G_ST  = 4'd5;
   localparam logic [3:0] G_RM  = 4'd6;
   localparam logic [3:0] G_EXT = 4'd7;
   localparam logic [3:0] G_OT  = 4'd8;
   localparam logic [3:0] G_RT  = 4'd9;

   typedef struct {
      logic [3:0]  grp;
      logic [3:0]  op;
      logic [3:0]  rg1;
      logic [3:0]  rg2;
      logic [7:0]  val;
      logic [15:0] pc;
      logic [15:0] tgt;
      logic [15:0] ext;
      logic [2:0]  err;
      logic [15:0] word;
   } vec_t;

   typedef struct {
      logic [15:0] word;
      logic        last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   log_hs   = 1'b0;
   exp_t exp_q[$];
   logic [2:0] err_q[$];
   int   hs_q[$];
   exp_t mon_e;
   logic [2:0] mon_err;
   vec_t vecs[$];

   encode_unit_if bus();

   encode_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] g, input logic [3:0] op, input logic [3:0] r1,
                               input logic [3:0] r2, input logic [7:0] v, input logic [15:0] pc,
                               input logic [15:0] tgt, input logic [15:0] ext,
                               input logic [2:0] err, input logic [15:0] w);
      vec_t t;
      t.grp = g; t.op = op; t.rg1 = r1; t.rg2 = r2; t.val = v;
      t.pc = pc; t.tgt = tgt; t.ext = ext; t.err = err; t.word = w;
      return t;
   endfunction

   // Scoreboard: compare every word handshake and every error pulse against expectations.
   always @(negedge clk) begin
      if (bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)", bus.out_word, $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk("out_word", 32'(bus.out_word), 32'(mon_e.word));
            chk("out_last", 32'(bus.out_last), 32'(mon_e.last));
         end
         if (log_hs) hs_q.push_back(cyc);
      end
      if (bus.err_valid) begin
         if (err_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_err: got code %0d, expected no error (t=%0t)", bus.err_code, $time);
         end else begin
            mon_err = err_q.pop_front();
            chk("err_code", 32'(bus.err_code), 32'(mon_err));
         end
      end
   end

   task automatic scramble();
      bus.in_group    = 4'($urandom);
      bus.in_operator = 4'($urandom);
      bus.in_rg1      = 4'($urandom);
      bus.in_rg2      = 4'($urandom);
      bus.in_val      = 8'($urandom);
      bus.in_pc       = 16'($urandom);
      bus.in_target   = 16'($urandom);
      bus.in_ext      = 16'($urandom);
   endtask

   // Present one instruction, wait (bounded) for acceptance, then garble the fields.
   task automatic drive_item(input vec_t v);
      bit   ok = 1'b0;
      exp_t e;
      bus.in_group = v.grp; bus.in_operator = v.op; bus.in_rg1 = v.rg1; bus.in_rg2 = v.rg2;
      bus.in_val = v.val; bus.in_pc = v.pc; bus.in_target = v.tgt; bus.in_ext = v.ext;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready=0, expected 1 within 100 cycles");
      end else if (v.err != 3'd0) begin
         err_q.push_back(v.err);
      end else begin
         e.word = v.word;
         e.last = (v.grp != G_EXT);
         exp_q.push_back(e);
         if (v.grp == G_EXT) begin
            e.word = v.ext;
            e.last = 1'b1;
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      scramble();
   endtask

   task automatic drain();
      int k = 0;
      while ((exp_q.size() != 0 || err_q.size() != 0) && k < 50) begin
         @(posedge clk);
         k++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("drain_words_left", 32'(exp_q.size()), 32'd0);
      chk("drain_errs_left", 32'(err_q.size()), 32'd0);
      exp_q.delete();
      err_q.delete();
   endtask

   initial begin
      vecs.push_back(mk(G_MC, 4'h2, 4'h3, 4'h0, 8'h5A, 16'h0000, 16'h0000, 16'h0, 3'd0, 16'h5A32));
      vecs.push_back(mk(G_MC, 4'h4, 4'hF, 4'h0, 8'hFF, 16'h0000, 16'h0000, 16'h0, 3'd0, 16'hFFF4));
      vecs.push_back(mk(G_MC, 4'h3, 4'h1, 4'h0, 8'h11, 16'h0000, 16'h0000, 16'h0, 3'd2, 16'h0000));
      vecs.push_back(mk(G_MC, 4'h7, 4'h1, 4'h0, 8'h11, 16'h0000, 16'h0000, 16'h0, 3'd2, 16'h0000));
      vecs.push_back(mk(G_MR, 4'h4, 4'h1, 4'h2, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd0, 16'h2147));
      vecs.push_back(mk(G_BR, 4'h5, 4'h0, 4'h0, 8'h00, 16'h0100, 16'h0100, 16'h0, 3'd0, 16'h012B));
      vecs.push_back(mk(G_BR, 4'h1, 4'h0, 4'h0, 8'h00, 16'h0200, 16'h0100, 16'h0, 3'd0, 16'h810B));
      vecs.push_back(mk(G_BR, 4'h0, 4'h0, 4'h0, 8'h00, 16'h0202, 16'h0100, 16'h0, 3'd0, 16'h8003));
      vecs.push_back(mk(G_BR, 4'h2, 4'h0, 4'h0, 8'h00, 16'h0000, 16'h00FD, 16'h0, 3'd0, 16'h7F93));
      vecs.push_back(mk(G_BR, 4'h2, 4'h0, 4'h0, 8'h00, 16'h0000, 16'h00FE, 16'h0, 3'd4, 16'h0000));
      vecs.push_back(mk(G_BR, 4'h0, 4'h0, 4'h0, 8'h00, 16'h0203, 16'h0100, 16'h0, 3'd4, 16'h0000));
      vecs.push_back(mk(G_BR, 4'h0, 4'h0, 4'h0, 8'h00, 16'h1000, 16'h1200, 16'h0, 3'd4, 16'h0000));
      vecs.push_back(mk(G_BR, 4'h0, 4'h0, 4'h0, 8'h00, 16'hFFF0, 16'h0010, 16'h0, 3'd4, 16'h0000));
      vecs.push_back(mk(G_ER, 4'hA, 4'h3, 4'h2, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd0, 16'h174F));
      vecs.push_back(mk(G_ER, 4'h0, 4'h4, 4'h0, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd3, 16'h0000));
      vecs.push_back(mk(G_ER, 4'h0, 4'h0, 4'h8, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd3, 16'h0000));
      vecs.push_back(mk(G_SR, 4'h5, 4'h9, 4'h0, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd0, 16'h255F));
      vecs.push_back(mk(G_SR, 4'h0, 4'h9, 4'h0, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd2, 16'h0000));
      vecs.push_back(mk(G_ST, 4'h1, 4'h2, 4'h0, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd0, 16'h085F));
      vecs.push_back(mk(G_ST, 4'h3, 4'h2, 4'h0, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd2, 16'h0000));
      vecs.push_back(mk(G_RM, 4'h5, 4'hC, 4'h3, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd0, 16'hF2BF));
      vecs.push_back(mk(G_RM, 4'h8, 4'h0, 4'h5, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd2, 16'h0000));
      vecs.push_back(mk(G_RM, 4'h1, 4'h0, 4'h4, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd3, 16'h0000));
      vecs.push_back(mk(G_OT, 4'h2, 4'h0, 4'h0, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd0, 16'h02FF));
      vecs.push_back(mk(G_OT, 4'h3, 4'h0, 4'h0, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd2, 16'h0000));
      vecs.push_back(mk(G_RT, 4'h7, 4'h0, 4'h0, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd0, 16'h07FF));
      vecs.push_back(mk(G_RT, 4'h2, 4'h0, 4'h0, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd2, 16'h0000));
      vecs.push_back(mk(G_EXT, 4'h3, 4'h0, 4'h0, 8'h00, 16'h0000, 16'h0000, 16'hBEEF, 3'd0, 16'h037F));
      vecs.push_back(mk(4'hA, 4'h0, 4'h0, 4'h0, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd1, 16'h0000));
      vecs.push_back(mk(4'hC, 4'h0, 4'h2, 4'h3, 8'h00, 16'h0000, 16'h0000, 16'h0, 3'd1, 16'h0000));
      vecs.push_back(mk(4'hF, 4'h3, 4'h4, 4'h9, 8'h00, 16'h1000, 16'h1200, 16'h0, 3'd1, 16'h0000));

      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      scramble();
      #12;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_word", 32'(bus.out_word), 32'd0);
      chk("rst_out_last", 32'(bus.out_last), 32'd0);
      chk("rst_err_valid", 32'(bus.err_valid), 32'd0);
      chk("rst_err_code", 32'(bus.err_code), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

      // Table: every group, legal and illegal, with the sink always ready.
      bus.out_ready = 1'b1;
      foreach (vecs[i]) drive_item(vecs[i]);
      drain();

      // Extended instruction under 3 cycles of backpressure.
      bus.out_ready = 1'b0;
      drive_item(mk(G_EXT, 4'h3, 4'h0, 4'h0, 8'h00, 16'h0, 16'h0, 16'hBEEF, 3'd0, 16'h037F));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_out_word", 32'(bus.out_word), 32'h037F);
         chk("bp_out_last", 32'(bus.out_last), 32'd0);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         @(posedge clk);
         #1;
         scramble();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("ext_word1_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("ext_word2_out_last", 32'(bus.out_last), 32'd1);
      chk("ext_word2_in_ready", 32'(bus.in_ready), 32'd1);
      drain();

      // Reset while the second word of an extended instruction is pending.
      bus.out_ready = 1'b0;
      drive_item(mk(G_EXT, 4'h3, 4'h0, 4'h0, 8'h00, 16'h0, 16'h0, 16'hBEEF, 3'd0, 16'h037F));
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk("pre_rst_out_word", 32'(bus.out_word), 32'hBEEF);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("async_rst_out_word", 32'(bus.out_word), 32'd0);
      chk("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Ten back-to-back single-word instructions must stream one per cycle.
      hs_q.delete();
      log_hs = 1'b1;
      for (int i = 0; i < 10; i++) begin
         logic [3:0] op, r1, r2;
         op = 4'(i);
         r1 = 4'(i + 1);
         r2 = 4'(15 - i);
         drive_item(mk(G_MR, op, r1, r2, 8'h00, 16'h0, 16'h0, 16'h0, 3'd0,
                       {r2, r1, op, 4'b0111}));
      end
      drain();
      log_hs = 1'b0;
      chk("b2b_count", 32'(hs_q.size()), 32'd10);
      for (int i = 1; i < hs_q.size(); i++)
         chk("b2b_consecutive", 32'(hs_q[i] - hs_q[i-1]), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
